// File: rtl/pipeline_interlock_if.sv
// Decode-packet bundle between the decode stage and the interlock controller.
// The master side presents the packet and the slave side returns the issue mask.
interface pipeline_interlock_if #(
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned REG_AW  = 5
);
  logic [ISSUE_W-1:0]        D_valid;
  logic [ISSUE_W*REG_AW-1:0] D_rs;
  logic [ISSUE_W*REG_AW-1:0] D_rt;
  logic [ISSUE_W*REG_AW-1:0] D_waddr;
  logic [ISSUE_W-1:0]        D_is_load;
  logic [ISSUE_W-1:0]        D_issue_mask;

  modport master (
    output D_valid, D_rs, D_rt, D_waddr, D_is_load,
    input  D_issue_mask
  );

  modport slave (
    input  D_valid, D_rs, D_rt, D_waddr, D_is_load,
    output D_issue_mask
  );
endinterface

// File: rtl/pipeline_interlock.sv
// Interlock / flush controller for an N-issue in-order F/D/E/M/W pipeline.
// A per-register scoreboard tracks in-flight loads, an intra-packet check splits
// dependent packets, and a small FSM sequences the divider with exception abort.
// Optional: define INTERLOCK_PERF_CNT_EN to build the performance counters;
// without it the perf outputs are tied to 0.
module pipeline_interlock #(
  parameter int unsigned ISSUE_W  = 2,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_stall,
  input  logic                d_stall,
  pipeline_interlock_if.slave dec,
  input  logic                E_branch_taken,
  input  logic                E_div_start,
  input  logic                div_done,
  input  logic                M_except,
  output logic                longest_stall,
  output logic                div_cancel,
  output logic                F_ena,
  output logic                D_ena,
  output logic                E_ena,
  output logic                M_ena,
  output logic                W_ena,
  output logic                F_flush,
  output logic                D_flush,
  output logic                E_flush,
  output logic                M_flush,
  output logic                W_flush,
  output logic [CNT_W-1:0]    perf_load_stall,
  output logic [CNT_W-1:0]    perf_mem_stall,
  output logic [CNT_W-1:0]    perf_flush
);

  localparam int unsigned NumRegs = 2 ** REG_AW;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  logic [2:0]         r_sb_cnt [NumRegs];
  div_state_e         r_div_state;
  logic [REG_AW-1:0]  w_rs [ISSUE_W];
  logic [REG_AW-1:0]  w_rt [ISSUE_W];
  logic [REG_AW-1:0]  w_wa [ISSUE_W];
  logic [ISSUE_W-1:0] w_hazard;
  logic [ISSUE_W-1:0] w_mask;
  logic               w_lwstall;
  logic               w_div_busy;
  logic               w_sb_set_en;

  // Unpack the per-slot register fields.
  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      w_rs[k] = dec.D_rs[k*REG_AW +: REG_AW];
      w_rt[k] = dec.D_rt[k*REG_AW +: REG_AW];
      w_wa[k] = dec.D_waddr[k*REG_AW +: REG_AW];
    end
  end

  // Per-slot hazard: pending load on a source, or a lower slot in the packet loads it.
  // Entry 0 is never set, so $0 sources can never hit the scoreboard.
  always_comb begin
    w_hazard = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (dec.D_valid[k] && ((r_sb_cnt[w_rs[k]] != 3'd0) || (r_sb_cnt[w_rt[k]] != 3'd0))) begin
        w_hazard[k] = 1'b1;
      end
      for (int j = 0; j < k; j++) begin
        if (dec.D_is_load[j] && (w_wa[j] != '0) &&
            ((w_wa[j] == w_rs[k]) || (w_wa[j] == w_rt[k]))) begin
          w_hazard[k] = 1'b1;
        end
      end
    end
  end

  // In-order issue: a slot leaves D only if no slot at or below it hazards.
  always_comb begin
    logic v_blocked;
    v_blocked = 1'b0;
    w_mask    = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      v_blocked = v_blocked | w_hazard[k];
      w_mask[k] = dec.D_valid[k] & ~v_blocked;
    end
  end

  assign dec.D_issue_mask = w_mask;

  assign w_lwstall     = dec.D_valid[0] & ~w_mask[0];
  assign w_div_busy    = (r_div_state == StBusy) |
                         ((r_div_state == StIdle) & E_div_start & ~M_except);
  assign longest_stall = i_stall | d_stall | w_div_busy;
  assign div_cancel    = (r_div_state == StBusy) & M_except;

  assign F_ena   = ~(w_lwstall | longest_stall);
  assign D_ena   = F_ena;
  assign E_ena   = ~longest_stall;
  assign M_ena   = E_ena;
  // W must retire the excepting instruction even while the divider holds the pipe.
  assign W_ena   = ~longest_stall | (w_div_busy & M_except);

  assign F_flush = 1'b0;
  assign W_flush = 1'b0;
  assign D_flush = M_except | E_branch_taken;
  assign E_flush = M_except;
  assign M_flush = M_except;

  assign w_sb_set_en = D_ena & ~D_flush;

  // Scoreboard: clear on exception, else count down on E advance; new loads override.
  always_ff @(posedge clk) begin
    if (!resetn || M_except) begin
      for (int r = 0; r < NumRegs; r++) begin
        r_sb_cnt[r] <= 3'd0;
      end
    end else begin
      if (E_ena) begin
        for (int r = 1; r < NumRegs; r++) begin
          if (r_sb_cnt[r] != 3'd0) begin
            r_sb_cnt[r] <= r_sb_cnt[r] - 3'd1;
          end
        end
      end
      // Later slots are assigned last, so the higher slot wins on a shared target.
      if (w_sb_set_en) begin
        for (int k = 0; k < ISSUE_W; k++) begin
          if (w_mask[k] && dec.D_is_load[k] && (w_wa[k] != '0)) begin
            r_sb_cnt[w_wa[k]] <= 3'(LOAD_LAT);
          end
        end
      end
    end
  end

  // Divider sequencing; an exception aborts a busy divide ahead of div_done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_div_state <= StIdle;
    end else begin
      case (r_div_state)
        StIdle: if (E_div_start && !M_except) r_div_state <= StBusy;
        StBusy: begin
          if (M_except)      r_div_state <= StIdle;
          else if (div_done) r_div_state <= StDone;
        end
        StDone:  r_div_state <= StIdle;
        default: r_div_state <= StIdle;
      endcase
    end
  end

`ifdef INTERLOCK_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_load;
  logic [CNT_W-1:0] r_perf_mem;
  logic [CNT_W-1:0] r_perf_flush;

  // Free-running event counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_perf_load  <= '0;
      r_perf_mem   <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_lwstall && !longest_stall) r_perf_load  <= r_perf_load + 1'b1;
      if (i_stall || d_stall)          r_perf_mem   <= r_perf_mem + 1'b1;
      if (D_flush)                     r_perf_flush <= r_perf_flush + 1'b1;
    end
  end

  assign perf_load_stall = r_perf_load;
  assign perf_mem_stall  = r_perf_mem;
  assign perf_flush      = r_perf_flush;
`else
  assign perf_load_stall = '0;
  assign perf_mem_stall  = '0;
  assign perf_flush      = '0;
`endif

endmodule
